// File: rtl/sdram_pkg.sv
// Shared SDRAM types: command encoding, {bank,row,col} address layout and client port index.
package sdram_pkg;

  localparam int unsigned BANK_W     = 2;
  localparam int unsigned ROW_W      = 13;
  localparam int unsigned COL_W      = 9;
  localparam int unsigned ADDR_W     = BANK_W + ROW_W + COL_W;
  localparam int unsigned PORT_IDX_W = 2;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACTIVE,
    CMD_READ,
    CMD_WRITE,
    CMD_PRECHARGE,
    CMD_REFRESH,
    CMD_LOAD_MODE
  } sdram_cmd_e;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } sdram_addr_t;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Small FIFO of read-owner tags; DEPTH must be a power of two (>= 2) so pointers wrap freely.
module sdram_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-client SDRAM request arbiter with a single hold register and in-order read-return routing.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed lowest-port-first priority instead of round-robin.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned TAG_DEPTH  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            req_valid_i,
  input  logic [NUM_PORTS-1:0]            req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS*BUS_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_PORTS-1:0]            req_ready_o,
  output logic [NUM_PORTS-1:0]            rsp_valid_o,
  output logic [BUS_WIDTH-1:0]            rsp_data_o,
  input  logic                            ctrl_enabled_i,
  input  logic                            ctrl_ready_i,
  output logic [ADDR_WIDTH-1:0]           ctrl_addr_o,
  output logic                            ctrl_r_valid_o,
  output logic                            ctrl_w_valid_o,
  output logic [BUS_WIDTH-1:0]            ctrl_write_o,
  input  logic                            ctrl_r_valid_i,
  input  logic [BUS_WIDTH-1:0]            ctrl_read_i,
  output logic                            error_o
);

  localparam int unsigned CNT_W     = $clog2(TAG_DEPTH) + 1;
  localparam port_idx_t   LAST_PORT = port_idx_t'(NUM_PORTS - 1);

  logic                  hold_valid;
  logic                  hold_we;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [BUS_WIDTH-1:0]  hold_wdata;
  port_idx_t             hold_port;
  port_idx_t             rr_ptr;
  port_idx_t             grant;
  port_idx_t             tag_out;
  logic                  grant_valid;
  logic                  grant_we;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [BUS_WIDTH-1:0]  grant_wdata;
  logic                  accept;
  logic                  ctrl_hs;
  logic                  read_block;
  logic                  tag_push;
  logic                  tag_full;
  logic                  tag_empty;
  logic [CNT_W-1:0]      tag_count;
  int unsigned           best_off;
  int unsigned           off;

  // Grant selection: valid port closest to rr_ptr going upward (or lowest index when fixed).
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    best_off    = NUM_PORTS;
    off         = 0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grant_valid = 1'b1;
        grant       = port_idx_t'(i);
      end
    end
`else
    for (int j = 0; j < NUM_PORTS; j++) begin
      off = (32'(j) + NUM_PORTS - 32'(rr_ptr)) % NUM_PORTS;
      if (req_valid_i[j] && (off < best_off)) begin
        best_off    = off;
        grant_valid = 1'b1;
        grant       = port_idx_t'(j);
      end
    end
`endif
  end

  always_comb begin
    grant_we    = 1'b0;
    grant_addr  = '0;
    grant_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == port_idx_t'(i)) begin
        grant_we    = req_we_i[i];
        grant_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        grant_wdata = req_wdata_i[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Read blocking uses the registered tag count; a same-cycle return does not unblock.
  assign read_block = (tag_count == CNT_W'(TAG_DEPTH));
  assign accept     = ~rst_i & ctrl_enabled_i & ~hold_valid & grant_valid
                    & ~(~grant_we & read_block);

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_ready_o[i] = accept & (grant == port_idx_t'(i));
    end
  end

  assign ctrl_addr_o    = hold_addr;
  assign ctrl_write_o   = hold_wdata;
  assign ctrl_r_valid_o = hold_valid & ~hold_we;
  assign ctrl_w_valid_o = hold_valid & hold_we;
  assign ctrl_hs        = ctrl_ready_i & hold_valid;
  assign tag_push       = ctrl_ready_i & ctrl_r_valid_o & ~tag_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_port  <= '0;
      rr_ptr     <= '0;
    end else begin
      if (ctrl_hs) hold_valid <= 1'b0;
      if (accept) begin
        hold_valid <= 1'b1;
        hold_we    <= grant_we;
        hold_addr  <= grant_addr;
        hold_wdata <= grant_wdata;
        hold_port  <= grant;
        rr_ptr     <= (grant == LAST_PORT) ? '0 : grant + 1'b1;
      end
    end
  end

  sdram_tag_fifo #(
    .WIDTH ($bits(port_idx_t)),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (tag_push),
    .pop   (ctrl_r_valid_i),
    .wdata (hold_port),
    .rdata (tag_out),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Read return: route to the oldest tag, or flag an orphan return.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      error_o     <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      if (ctrl_r_valid_i) begin
        if (tag_empty) begin
          error_o <= 1'b1;
        end else begin
          rsp_data_o <= ctrl_read_i;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (tag_out == port_idx_t'(i)) rsp_valid_o[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of client ports (2..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 24, the {bank,row,col} word address width.
REQ-003 SHALL have parameter BUS_WIDTH, default 16, data width.
REQ-004 SHALL have parameter TAG_DEPTH, default 2, maximum outstanding reads (power of two).
REQ-005 SHALL have port clk_i, in, 1: the single clock. All logic is rising-edge.
REQ-006 SHALL have port rst_i, in, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid_i, in, NUM_PORTS: per-client request valid.
REQ-008 SHALL have port req_we_i, in, NUM_PORTS: per-client 1=write, 0=read.
REQ-009 SHALL have port req_addr_i, in, NUM_PORTS x ADDR_WIDTH: per-client address.
REQ-010 SHALL have port req_wdata_i, in, NUM_PORTS x BUS_WIDTH: per-client write data.
REQ-011 SHALL have port req_ready_o, out, NUM_PORTS: per-client request accepted when valid&ready.
REQ-012 SHALL have port rsp_valid_o, out, NUM_PORTS: one-cycle read-data pulse to the owning client.
REQ-013 SHALL have port rsp_data_o, out, BUS_WIDTH: read data, shared by all clients.
REQ-014 SHALL have ports ctrl_enabled_i (in, 1) and ctrl_ready_i (in, 1): the controller's init-done and idle-ready signals.
REQ-015 SHALL have ports ctrl_addr_o (out, ADDR_WIDTH), ctrl_r_valid_o (out, 1), ctrl_w_valid_o (out, 1) and ctrl_write_o (out, BUS_WIDTH): the request to the controller.
REQ-016 SHALL have ports ctrl_r_valid_i (in, 1) and ctrl_read_i (in, BUS_WIDTH): read return from the controller.
REQ-017 SHALL have port error_o, out, 1: sticky flag for a read return with no outstanding tag.

Function
REQ-018 SHALL hold one request in a hold register (hold_valid, addr, we, wdata, port).
REQ-019 SHALL drive ctrl_* only from the hold register.
REQ-020 SHALL drive ctrl_r_valid_o = hold_valid&!we and ctrl_w_valid_o = hold_valid&we.
REQ-021 SHALL treat a controller handshake as ctrl_ready_i & (ctrl_r_valid_o|ctrl_w_valid_o) in the same cycle, and clear hold_valid on the next edge.
REQ-022 SHALL select a grant combinationally among ports with req_valid_i, searching from rr_ptr upward with wrap-around.
REQ-023 SHALL assert req_ready_o for the granted port only, and only when ctrl_enabled_i & !hold_valid & !(granted request is a read & tag count == TAG_DEPTH).
REQ-024 SHALL keep req_ready_o low for all ports while any of those conditions is false.
REQ-025 On client accept in cycle N, SHALL have the hold register valid and ctrl_*_valid_o high in cycle N+1.
REQ-026 On client accept, SHALL set rr_ptr to (granted port + 1) mod NUM_PORTS.
REQ-027 SHALL push the hold register's port index into the tag FIFO on a controller read handshake.
REQ-028 SHALL NOT push a tag on a controller write handshake.
REQ-029 On ctrl_r_valid_i, SHALL pop the tag FIFO and register ctrl_read_i into rsp_data_o.
REQ-030 SHALL pulse rsp_valid_o[popped tag] in the cycle after ctrl_r_valid_i (1-cycle return latency).
REQ-031 SHALL return reads in controller order.
REQ-032 SHALL allow a push and a pop in the same cycle, leaving the count unchanged even when full.
REQ-033 SHALL compute read blocking from the registered count, ignoring a same-cycle pop.
REQ-034 On ctrl_r_valid_i with an empty tag FIFO, SHALL drop the data, keep rsp_valid_o all zero, and set error_o until reset.
REQ-035 SHALL hold a request in the hold register, not cancel it, if ctrl_enabled_i falls while the request is held.
REQ-036 SHALL keep the tag count TAG_DEPTH-sized plus one bit, with read and write pointers that wrap modulo TAG_DEPTH.

Reset
REQ-037 While rst_i is high, SHALL force: hold_valid=0; ctrl_r_valid_o=0; ctrl_w_valid_o=0; ctrl_addr_o=0; ctrl_write_o=0; rr_ptr=0; tag FIFO empty; rsp_valid_o=0; rsp_data_o=0; error_o=0; req_ready_o=0.
REQ-038 SHALL discard in-flight tags on a mid-operation reset, so a later stray ctrl_r_valid_i sets error_o (REQ-034).

Configuration
REQ-039 With SDRAM_ARB_FIXED_PRIO_EN defined, SHALL grant the lowest-numbered valid port and ignore rr_ptr.
REQ-040 Without SDRAM_ARB_FIXED_PRIO_EN, SHALL use round-robin per REQ-022 and REQ-026.

Structure
REQ-041 SHALL take the shared address struct {bank,row,col} and the port-index typedef from package sdram_pkg, alongside the existing SDRAM command enum.
REQ-042 SHALL implement the tag queue as sub-module sdram_tag_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count).

Verification
REQ-043 SHALL cover: ctrl_enabled_i=0 with port0 read valid -> req_ready_o=0; enabled at cycle 10 -> ready cycle 10, ctrl_r_valid_o at 11 with ctrl_addr_o=port0 address.
REQ-044 SHALL cover: both ports valid continuously, ctrl_ready_i always 1 -> grants alternate 0,1,0,1 (fixed-prio build: 0,0,0,0).
REQ-045 SHALL cover: port1 write addr 0x012345 data 0xBEEF -> ctrl_w_valid_o with those values, no tag pushed, no rsp_valid_o.
REQ-046 SHALL cover: TAG_DEPTH=2, three reads from port0,1,0 with no returns -> third stalls; returns 0xAAAA then 0x5555 -> rsp_valid_o[0] then rsp_valid_o[1], each 1 cycle after ctrl_r_valid_i; third read then proceeds.
REQ-047 SHALL cover: ctrl_r_valid_i with empty FIFO -> error_o=1 and stays 1; rst_i pulse -> error_o=0.
REQ-048 SHALL cover: rst_i asserted with hold_valid=1 and 1 tag outstanding -> all outputs 0 asynchronously; post-reset return sets error_o.
